// File: rtl/hdmi_to_blocks.sv
// rtl/hdmi_to_blocks.sv - HDMI raster to 8x8 block converter using a ping-pong 8-line strip buffer
// Defining HDMI_TO_BLOCKS_STATS_EN adds the frame_cnt/drop_cnt statistics outputs.
module hdmi_to_blocks #(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hdmi_v_sync,
  input  logic                     hdmi_h_sync,
  input  logic                     hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                     blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                     blk_sob,
  output logic                     blk_eob,
  output logic                     blk_sof,
  output logic                     ovf
`ifdef HDMI_TO_BLOCKS_STATS_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int COLS    = X_RES / N;
  localparam int WPB     = 8 / N;
  localparam int BEATS   = 64 / N;
  localparam int BLKS    = X_RES / 8;
  localparam int STRIPS  = Y_RES / 8;
  localparam int DEPTH   = 16 * COLS;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int BLK_W   = (BLKS > 1) ? $clog2(BLKS) : 1;
  localparam int STRIP_W = $clog2(STRIPS + 1);
  localparam int ADDR_W  = $clog2(DEPTH);

  typedef enum logic {IDLE, RD} state_t;

  logic               vs_q, hs_q;
  logic [COL_W-1:0]   col_q;
  logic [2:0]         line_q;
  logic [STRIP_W-1:0] strip_q;
  logic               bank_w_q;
  state_t             state_q;
  logic               rd_bank_q, sof_q;
  logic [BLK_W-1:0]   blk_q;
  logic [BEAT_W-1:0]  beat_q;

  logic               vs_rise, hs_rise, wr_en, strip_done, handoff;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;

  logic [N-1:0][7:0]  ram_y  [DEPTH];
  logic [N-1:0][7:0]  ram_cr [DEPTH];
  logic [N-1:0][7:0]  ram_cb [DEPTH];

  assign vs_rise    = hdmi_v_sync & ~vs_q;
  assign hs_rise    = hdmi_h_sync & ~hs_q;
  assign wr_en      = hdmi_data_valid & ~vs_rise & ~hs_rise & (strip_q < STRIP_W'(STRIPS));
  assign strip_done = wr_en & (col_q == COL_W'(COLS - 1)) & (line_q == 3'd7);
  // The reader is still busy on its final beat, so a coincident completion is an overrun.
  assign handoff    = strip_done & (state_q == IDLE);

  assign wr_addr = ADDR_W'((32'(bank_w_q) * 8 + 32'(line_q)) * COLS + 32'(col_q));
  assign rd_addr = ADDR_W'((32'(rd_bank_q) * 8 + 32'(beat_q) / WPB) * COLS
                           + 32'(blk_q) * WPB + 32'(beat_q) % WPB);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_y[wr_addr]  <= hdmi_data_y;
      ram_cr[wr_addr] <= hdmi_data_cr;
      ram_cb[wr_addr] <= hdmi_data_cb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      col_q    <= '0;
      line_q   <= '0;
      strip_q  <= '0;
      bank_w_q <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      vs_q <= hdmi_v_sync;
      hs_q <= hdmi_h_sync;
      if (vs_rise) begin
        col_q   <= '0;
        line_q  <= '0;
        strip_q <= '0;
      end else if (hs_rise) begin
        col_q <= '0;
      end else if (wr_en) begin
        if (col_q == COL_W'(COLS - 1)) begin
          col_q  <= '0;
          line_q <= line_q + 3'd1;
          if (strip_done) begin
            strip_q <= strip_q + STRIP_W'(1);
            // On overrun the writer keeps its bank and the strip is simply overwritten.
            if (handoff) bank_w_q <= ~bank_w_q;
            else         ovf      <= 1'b1;
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      sof_q       <= 1'b0;
      blk_q       <= '0;
      beat_q      <= '0;
      blk_valid   <= 1'b0;
      blk_sob     <= 1'b0;
      blk_eob     <= 1'b0;
      blk_sof     <= 1'b0;
      blk_data_y  <= '0;
      blk_data_cr <= '0;
      blk_data_cb <= '0;
    end else begin
      blk_valid <= 1'b0;
      blk_sob   <= 1'b0;
      blk_eob   <= 1'b0;
      blk_sof   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handoff) begin
            state_q   <= RD;
            rd_bank_q <= bank_w_q;
            sof_q     <= (strip_q == '0);
            blk_q     <= '0;
            beat_q    <= '0;
          end
        end
        RD: begin
          blk_valid   <= 1'b1;
          blk_data_y  <= ram_y[rd_addr];
          blk_data_cr <= ram_cr[rd_addr];
          blk_data_cb <= ram_cb[rd_addr];
          blk_sob     <= (beat_q == '0);
          blk_eob     <= (beat_q == BEAT_W'(BEATS - 1));
          blk_sof     <= (beat_q == '0) && (blk_q == '0) && sof_q;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_q <= '0;
            if (blk_q == BLK_W'(BLKS - 1)) state_q <= IDLE;
            else                           blk_q   <= blk_q + BLK_W'(1);
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HDMI_TO_BLOCKS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (vs_rise) frame_cnt <= frame_cnt + 16'd1;
      if (strip_done && !handoff && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
